// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory and register-file bundle of the sequencer.
// The master side is the sequencer; the slave side is memory plus regfile.
interface cpu_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [3:0]  read_reg_1;
  logic [3:0]  read_reg_2;
  logic [15:0] reg_1_data;
  logic [15:0] reg_2_data;
  logic        reg_write;
  logic [3:0]  write_reg_no;
  logic [15:0] input_data;
  logic [15:0] pc;
  logic        halted;

  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output read_reg_1, read_reg_2,
    input  reg_1_data, reg_2_data,
    output reg_write, write_reg_no, input_data,
    output pc, halted
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  read_reg_1, read_reg_2,
    output reg_1_data, reg_2_data,
    input  reg_write, write_reg_no, input_data,
    input  pc, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback control
// for the 16-bit datapath, with PC, IR and a small internal ALU.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             clear,
  cpu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] alu_q, alu_d;
  logic        halted_q, halted_d;

  logic        we_raw;
  logic        rw_raw;
  logic [3:0]  opcode;
  logic [15:0] r1, r2;
  logic [15:0] sext12, sext4;

  assign opcode = ir_q[15:12];
  assign r1     = bus.reg_1_data;
  assign r2     = bus.reg_2_data;
  assign sext12 = {{4{ir_q[11]}}, ir_q[11:0]};
  assign sext4  = {{12{ir_q[11]}}, ir_q[11:8]};

  assign bus.read_reg_1   = ir_q[7:4];
  assign bus.read_reg_2   = ir_q[3:0];
  assign bus.write_reg_no = ir_q[11:8];
  assign bus.input_data   = (opcode == 4'h5) ? bus.mem_rdata : alu_q;
  assign bus.pc           = pc_q;
  assign bus.halted       = halted_q;
  // clear blocks any write in the cycle it is raised
  assign bus.mem_we       = we_raw & ~clear;
  assign bus.reg_write    = rw_raw & ~clear;

  // next-state, datapath updates and bus strobes
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_d         = alu_q;
    we_raw        = 1'b0;
    rw_raw        = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_addr = pc_q;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_q + 16'd1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          4'h0: begin
            alu_d   = r1 + r2;
            state_d = S_WRITEBACK;
          end
          4'h1: begin
            alu_d   = r1 + {12'h000, ir_q[3:0]};
            state_d = S_WRITEBACK;
          end
          4'h2: begin
            alu_d   = r1 & r2;
            state_d = S_WRITEBACK;
          end
          4'h3: begin
            alu_d   = r1 | r2;
            state_d = S_WRITEBACK;
          end
          4'h4: begin
            alu_d   = r1 ^ r2;
            state_d = S_WRITEBACK;
          end
          4'h5: begin
            bus.mem_addr = r1;
            state_d      = S_WRITEBACK;
          end
          4'h6: begin
            bus.mem_addr  = r1;
            bus.mem_wdata = r2;
            we_raw        = 1'b1;
          end
          4'h7: pc_d = pc_q + sext12;
          4'h8: begin
            if (r1 == r2)
              pc_d = pc_q + sext4;
          end
          4'hF: state_d = S_HALT;
          default: ;
        endcase
      end
      S_WRITEBACK: begin
        rw_raw  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    halted_d = (state_d == S_HALT);
  end

  // state and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      alu_q    <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_q    <= alu_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random programs against an instruction-level model,
// plus directed reset, branch, halt and clear-during-store cases.
module tb_cpu_sequencer;
  localparam logic [15:0] RPC = 16'h0010;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic load = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .clear(clear),
    .bus(bus)
  );

  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] mmem [256];
  logic [15:0] rf [16];
  logic [15:0] rimg [16];
  logic [15:0] mreg [16];
  logic [15:0] mpc;
  bit          mhalt;
  logic [15:0] trace [$];

  int checks = 0;
  int failures = 0;

  assign bus.reg_1_data = rf[bus.read_reg_1];
  assign bus.reg_2_data = rf[bus.read_reg_2];

  // memory (aliased to 256 words) and register file environment
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      for (int i = 0; i < 16; i++) rf[i] <= rimg[i];
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.reg_write) rf[bus.write_reg_no] <= bus.input_data;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one instruction of the architectural machine
  task automatic model_step(output int cyc, output int nwe, output int nrw);
    logic [15:0] in, npc, a, b;
    logic [3:0] rd;
    in  = mmem[mpc[7:0]];
    npc = mpc + 16'd1;
    rd  = in[11:8];
    a   = mreg[in[7:4]];
    b   = mreg[in[3:0]];
    cyc = 3;
    nwe = 0;
    nrw = 0;
    case (in[15:12])
      4'h0: begin mreg[rd] = a + b; cyc = 4; nrw = 1; end
      4'h1: begin mreg[rd] = a + {12'h000, in[3:0]}; cyc = 4; nrw = 1; end
      4'h2: begin mreg[rd] = a & b; cyc = 4; nrw = 1; end
      4'h3: begin mreg[rd] = a | b; cyc = 4; nrw = 1; end
      4'h4: begin mreg[rd] = a ^ b; cyc = 4; nrw = 1; end
      4'h5: begin mreg[rd] = mmem[a[7:0]]; cyc = 4; nrw = 1; end
      4'h6: begin mmem[a[7:0]] = b; nwe = 1; end
      4'h7: npc = npc + {{4{in[11]}}, in[11:0]};
      4'h8: if (a == b) npc = npc + {{12{in[11]}}, in[11:8]};
      4'hF: mhalt = 1'b1;
      default: ;
    endcase
    mpc = npc;
  endtask

  task automatic start_run();
    @(negedge clk);
    clear = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 256; i++) mmem[i] = img[i];
    for (int i = 0; i < 16; i++) mreg[i] = rimg[i];
    mpc   = RPC;
    mhalt = 1'b0;
    trace.delete();
    chk("rst_addr", 32'(bus.mem_addr), 32'(RPC));
    chk("rst_pc", 32'(bus.pc), 32'(RPC));
    chk("rst_strb", 32'({bus.mem_we, bus.reg_write, bus.halted}), 32'd0);
    chk("rst_regno", 32'({bus.read_reg_1, bus.read_reg_2, bus.write_reg_no}), 32'd0);
    chk("rst_data", {bus.mem_wdata, bus.input_data}, 32'd0);
  endtask

  task automatic run(input int maxi);
    int cyc, ewe, erw, nwe, nrw, bad;
    start_run();
    for (int k = 0; k < maxi; k++) begin
      if (mhalt) begin
        chk("halted", 32'(bus.halted), 32'd1);
        nwe = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          nwe += int'(bus.mem_we) + int'(bus.reg_write);
          chk("halt_pc", 32'(bus.pc), 32'(mpc));
        end
        chk("halt_writes", 32'(nwe), 32'd0);
        break;
      end
      chk("fetch_addr", 32'(bus.mem_addr), 32'(mpc));
      chk("fetch_halted", 32'(bus.halted), 32'd0);
      trace.push_back(bus.mem_addr);
      model_step(cyc, ewe, erw);
      nwe = 0;
      nrw = 0;
      for (int c = 0; c < cyc; c++) begin
        nwe += int'(bus.mem_we);
        nrw += int'(bus.reg_write);
        @(negedge clk);
      end
      chk("we_count", 32'(nwe), 32'(ewe));
      chk("rw_count", 32'(nrw), 32'(erw));
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== mreg[i]) bad++;
    chk("regfile", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) bad++;
    chk("memory", 32'(bad), 32'd0);
  endtask

  logic [15:0] exp_tr [9];

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 16'h9000;
    for (int i = 0; i < 16; i++) rimg[i] = 16'h0000;

    // directed: ALU wrap, LD, ST, JMP, BEQ taken/not, self JMP
    rimg[1]  = 16'hFFFF;
    rimg[2]  = 16'h0002;
    rimg[4]  = 16'h0100;
    rimg[8]  = 16'h0020;
    rimg[9]  = 16'h1234;
    rimg[10] = 16'h7777;
    rimg[11] = 16'h7777;
    rimg[12] = 16'h1111;
    img[16'h00] = 16'hBEEF;
    img[16'h10] = 16'h0312;
    img[16'h11] = 16'h5540;
    img[16'h12] = 16'h6089;
    img[16'h13] = 16'h7FF1;
    img[16'h05] = 16'h8EAC;
    img[16'h06] = 16'h7FFD;
    img[16'h04] = 16'h8EAB;
    img[16'h03] = 16'h7FFF;
    run(10);
    exp_tr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0005,
               16'h0006, 16'h0004, 16'h0003, 16'h0003};
    chk("trace_len", 32'(trace.size()), 32'd10);
    for (int i = 0; i < 9; i++)
      if (i < trace.size())
        chk($sformatf("trace%0d", i), 32'(trace[i]), 32'(exp_tr[i]));
    chk("add_wrap", 32'(rf[3]), 32'h0001);
    chk("ld_data", 32'(rf[5]), 32'hBEEF);
    chk("st_data", 32'(mem[8'h20]), 32'h1234);

    // directed: halt, frozen PC, then clear while halted
    for (int i = 0; i < 256; i++) img[i] = 16'h9000;
    img[16'h10] = 16'hF000;
    run(5);
    chk("halt_pc_val", 32'(bus.pc), 32'h0011);

    // directed: clear raised during EXECUTE of a store
    img[16'h10] = 16'h6089;
    img[16'h20] = 16'h5555;
    start_run();
    @(negedge clk);
    @(negedge clk);
    chk("st_exec_addr", 32'(bus.mem_addr), 32'h0020);
    chk("st_exec_wdata", 32'(bus.mem_wdata), 32'h1234);
    chk("st_exec_we", 32'(bus.mem_we), 32'd1);
    clear = 1'b1;
    #1;
    chk("st_clr_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    chk("st_clr_mem", 32'(mem[8'h20]), 32'h5555);
    chk("st_clr_addr", 32'(bus.mem_addr), 32'(RPC));
    chk("st_clr_pc", 32'(bus.pc), 32'(RPC));

    // random programs and register contents
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) rimg[i] = 16'($urandom);
      run(50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
